// File: rtl/npn_pkg.sv
// -----------------------------------------------------------------------------
// npn_pkg
// Shared definitions for the sequential NPN canonizer:
//   MAX_VARS / MAX_PERMS  - largest supported function (4 inputs, 24 orderings)
//   PERM_TABLE            - all orderings of 4 variables in lexicographic order;
//                           entry bits [2i+1:2i] hold p[i], the variable that
//                           input i is routed to
//   factorial()           - permutation count for a given input count
//   cand_count()          - total candidates per scan
//   perm_slot()           - maps a contiguous permutation index for a smaller
//                           function onto the table entry that fixes the unused
//                           upper variables
//   state_t               - scan controller states
// -----------------------------------------------------------------------------
package npn_pkg;

    localparam int MAX_VARS  = 4;
    localparam int MAX_PERMS = 24;

    // Packs one ordering (p0, p1, p2, p3) into a table entry.
    function automatic logic [7:0] pm(input int p0, input int p1,
                                      input int p2, input int p3);
        return {2'(p3), 2'(p2), 2'(p1), 2'(p0)};
    endfunction

    localparam logic [7:0] PERM_TABLE [MAX_PERMS] = '{
        pm(0,1,2,3), pm(0,1,3,2), pm(0,2,1,3), pm(0,2,3,1),
        pm(0,3,1,2), pm(0,3,2,1), pm(1,0,2,3), pm(1,0,3,2),
        pm(1,2,0,3), pm(1,2,3,0), pm(1,3,0,2), pm(1,3,2,0),
        pm(2,0,1,3), pm(2,0,3,1), pm(2,1,0,3), pm(2,1,3,0),
        pm(2,3,0,1), pm(2,3,1,0), pm(3,0,1,2), pm(3,0,2,1),
        pm(3,1,0,2), pm(3,1,2,0), pm(3,2,0,1), pm(3,2,1,0)
    };

    function automatic int factorial(input int n);
        int r;
        r = 1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    function automatic int cand_count(input int nvars, input bit outneg);
        return factorial(nvars) * (2 ** nvars) * (outneg ? 2 : 1);
    endfunction

    // Index of the k-th table entry (in table order) whose variables at
    // positions >= nvars map to themselves. Out-of-range k falls back to 0,
    // the identity ordering.
    function automatic int perm_slot(input int nvars, input int k);
        int   seen;
        int   slot;
        logic fixes;
        seen = 0;
        slot = 0;
        for (int t = 0; t < MAX_PERMS; t++) begin
            fixes = 1'b1;
            for (int i = 0; i < MAX_VARS; i++) begin
                if (i >= nvars && int'(PERM_TABLE[t][2*i +: 2]) != i)
                    fixes = 1'b0;
            end
            if (fixes) begin
                if (seen == k) slot = t;
                seen++;
            end
        end
        return slot;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/npn_tt_transform.sv
// -----------------------------------------------------------------------------
// npn_tt_transform
// Combinational truth-table transform: tt_out(x) = oneg ^ tt(z), where
// z[p[i]] = x_i ^ neg[i] and p is the ordering selected by perm.
//   tt     in   TT_W      source truth table, bit m = f(m)
//   perm   in   PIDX_W    contiguous permutation index (0 = identity)
//   neg    in   NUM_VARS  input negation mask
//   oneg   in   1         output negation
//   tt_out out  TT_W      transformed truth table
// -----------------------------------------------------------------------------
module npn_tt_transform
    import npn_pkg::*;
#(
    parameter int NUM_VARS = 4,
    parameter int TT_W     = 2 ** NUM_VARS,
    parameter int PIDX_W   = 5
) (
    input  logic [TT_W-1:0]     tt,
    input  logic [PIDX_W-1:0]   perm,
    input  logic [NUM_VARS-1:0] neg,
    input  logic                oneg,
    output logic [TT_W-1:0]     tt_out
);

    localparam int ROM_D = 2 ** PIDX_W;

    // Full-depth ROM so any index value is legal; unused slots hold identity.
    logic [7:0] perm_rom [ROM_D];

    for (genvar k = 0; k < ROM_D; k++) begin : g_rom
        localparam int SLOT = perm_slot(NUM_VARS, k);
        assign perm_rom[k] = PERM_TABLE[SLOT];
    end

    logic [7:0]          pmap;
    logic [MAX_VARS-1:0] z;

    assign pmap = perm_rom[perm];

    always_comb begin
        tt_out = '0;
        z      = '0;
        for (int x = 0; x < TT_W; x++) begin
            z = '0;
            for (int i = 0; i < NUM_VARS; i++)
                z[pmap[2*i +: 2]] = x[i] ^ neg[i];
            tt_out[x] = oneg ^ tt[z[NUM_VARS-1:0]];
        end
    end

endmodule

// File: rtl/npn_canon_seq.sv
// -----------------------------------------------------------------------------
// npn_canon_seq
// Sequential NPN canonizer. Scans every (permutation, input negation, output
// negation) candidate of an accepted truth table, one per clock, and returns
// the numerically smallest candidate with the transform that produced it.
// Optional feature macro: NPN_OUTNEG_EN (enumerate output negation; otherwise
// NP classes only and out_oneg is tied low).
//   clk, rst   clock (rising) and asynchronous active-high reset
//   in_valid   in   truth table offered        in_ready  out  idle, can accept
//   in_tt      in   TT_W truth table
//   out_valid  out  result held                out_ready in   result consumed
//   out_tt     out  canonical truth table
//   out_perm   out  winning permutation index
//   out_neg    out  winning input negation mask
//   out_oneg   out  winning output negation
// -----------------------------------------------------------------------------
module npn_canon_seq
    import npn_pkg::*;
#(
    parameter int NUM_VARS = 4,
    parameter int TT_W     = 2 ** NUM_VARS,
    parameter int PIDX_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [TT_W-1:0]     in_tt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TT_W-1:0]     out_tt,
    output logic [PIDX_W-1:0]   out_perm,
    output logic [NUM_VARS-1:0] out_neg,
    output logic                out_oneg
);

`ifdef NPN_OUTNEG_EN
    localparam logic OUTNEG = 1'b1;
`else
    localparam logic OUTNEG = 1'b0;
`endif

    localparam int                NPERM     = factorial(NUM_VARS);
    localparam logic [PIDX_W-1:0] PERM_LAST = PIDX_W'(NPERM - 1);

    state_t              state, state_next;
    logic [TT_W-1:0]     tt_reg;
    logic [PIDX_W-1:0]   perm_cnt;
    logic [NUM_VARS-1:0] neg_cnt;
    logic                oneg_cnt;

    logic [TT_W-1:0]     best_tt;
    logic [PIDX_W-1:0]   best_perm;
    logic [NUM_VARS-1:0] best_neg;
    logic                best_oneg;
    logic                out_oneg_r;

    logic [TT_W-1:0]     cand_tt;
    logic                accept, first_cand, take;
    logic                oneg_wrap, neg_wrap, last_cand;

    npn_tt_transform #(
        .NUM_VARS (NUM_VARS),
        .TT_W     (TT_W),
        .PIDX_W   (PIDX_W)
    ) u_xform (
        .tt     (tt_reg),
        .perm   (perm_cnt),
        .neg    (neg_cnt),
        .oneg   (oneg_cnt),
        .tt_out (cand_tt)
    );

    assign accept     = in_valid && in_ready;
    // Without output negation the inner loop has a single step.
    assign oneg_wrap  = !OUTNEG || oneg_cnt;
    assign neg_wrap   = oneg_wrap && (neg_cnt == '1);
    assign last_cand  = neg_wrap && (perm_cnt == PERM_LAST);
    // Candidate (0,0,0) is f itself and seeds the best register; strict
    // less-than afterwards keeps the first of any tie.
    assign first_cand = (perm_cnt == '0) && (neg_cnt == '0) && !oneg_cnt;
    assign take       = first_cand || (cand_tt < best_tt);

    // ---- controller ---------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (last_cand) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---- candidate counters: perm outer, neg middle, oneg inner -------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perm_cnt <= '0;
            neg_cnt  <= '0;
            oneg_cnt <= 1'b0;
        end else if (accept) begin
            perm_cnt <= '0;
            neg_cnt  <= '0;
            oneg_cnt <= 1'b0;
        end else if (state == ST_SCAN) begin
            oneg_cnt <= OUTNEG && !oneg_cnt;
            if (oneg_wrap) begin
                neg_cnt <= neg_cnt + 1'b1;
                if (neg_wrap)
                    perm_cnt <= last_cand ? '0 : perm_cnt + 1'b1;
            end
        end
    end

    // ---- datapath: input capture and running minimum ------------------------
    always_ff @(posedge clk) begin
        if (accept)
            tt_reg <= in_tt;
        if (state == ST_SCAN && take) begin
            best_tt   <= cand_tt;
            best_perm <= perm_cnt;
            best_neg  <= neg_cnt;
            best_oneg <= oneg_cnt;
        end
    end

    // ---- result registers: loaded once at scan end, frozen until reset ------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_tt     <= '0;
            out_perm   <= '0;
            out_neg    <= '0;
            out_oneg_r <= 1'b0;
        end else if (state == ST_SCAN && last_cand) begin
            out_tt     <= take ? cand_tt  : best_tt;
            out_perm   <= take ? perm_cnt : best_perm;
            out_neg    <= take ? neg_cnt  : best_neg;
            out_oneg_r <= take ? oneg_cnt : best_oneg;
        end
    end

    assign out_oneg = OUTNEG && out_oneg_r;

endmodule

// File: tb/tb_npn_canon_seq.sv
module tb_npn_canon_seq;

`ifdef NPN_OUTNEG_EN
    localparam int K = 2;
`else
    localparam int K = 1;
`endif
    localparam int LAT4 = 24 * 16 * K;
    localparam int LAT2 = 2 * 4 * K;

    typedef struct {
        logic [15:0] tt;
        int          perm;
        int          neg;
        int          oneg;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 4-input instance
    logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic        a_in_ready, a_out_valid, a_out_oneg;
    logic [15:0] a_in_tt = 16'h0, a_out_tt;
    logic [4:0]  a_out_perm;
    logic [3:0]  a_out_neg;

    // 2-input instance
    logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic        b_in_ready, b_out_valid, b_out_oneg;
    logic [3:0]  b_in_tt = 4'h0, b_out_tt;
    logic [4:0]  b_out_perm;
    logic [1:0]  b_out_neg;

    // standalone transform for re-applying a reported transform
    logic [15:0] x_tt = 16'h0, x_out;
    logic [4:0]  x_perm = 5'd0;
    logic [3:0]  x_neg = 4'd0;
    logic        x_oneg = 1'b0;

    npn_canon_seq #(.NUM_VARS(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_tt(a_in_tt),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_tt(a_out_tt),
        .out_perm(a_out_perm), .out_neg(a_out_neg), .out_oneg(a_out_oneg)
    );

    npn_canon_seq #(.NUM_VARS(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_tt(b_in_tt),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_tt(b_out_tt),
        .out_perm(b_out_perm), .out_neg(b_out_neg), .out_oneg(b_out_oneg)
    );

    npn_tt_transform #(.NUM_VARS(4)) xf (
        .tt(x_tt), .perm(x_perm), .neg(x_neg), .oneg(x_oneg), .tt_out(x_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Brute force over the definition: orderings generated in lexicographic
    // order by the classic next-permutation step, each candidate evaluated
    // minterm by minterm.
    function automatic res_t model(input int nv, input logic [15:0] f, input int k);
        res_t        best;
        int          p [4];
        int          nperm, z, i, j, t;
        logic [15:0] g;
        bit          first;
        nperm = 1;
        for (int q = 2; q <= nv; q++) nperm = nperm * q;
        for (int q = 0; q < 4; q++) p[q] = q;
        first = 1'b1;
        best.tt = 16'h0; best.perm = 0; best.neg = 0; best.oneg = 0;
        for (int pidx = 0; pidx < nperm; pidx++) begin
            for (int n = 0; n < (1 << nv); n++) begin
                for (int o = 0; o < k; o++) begin
                    g = 16'h0;
                    for (int x = 0; x < (1 << nv); x++) begin
                        z = 0;
                        for (int b = 0; b < nv; b++)
                            if ((((x >> b) ^ (n >> b)) & 1) != 0) z = z | (1 << p[b]);
                        g[x] = f[z] ^ (o != 0);
                    end
                    if (first || g < best.tt) begin
                        best.tt = g; best.perm = pidx; best.neg = n; best.oneg = o;
                        first = 1'b0;
                    end
                end
            end
            i = nv - 2;
            while (i >= 0 && p[i] > p[i+1]) i--;
            if (i >= 0) begin
                j = nv - 1;
                while (p[j] < p[i]) j--;
                t = p[i]; p[i] = p[j]; p[j] = t;
                i = i + 1; j = nv - 1;
                while (i < j) begin
                    t = p[i]; p[i] = p[j]; p[j] = t;
                    i++; j--;
                end
            end
        end
        return best;
    endfunction

    // Offers f, measures latency, optionally holds out_ready low, then releases.
    task automatic run_a(input logic [15:0] f, input int hold, output res_t got);
        int cyc;
        check("a_ready_before", a_in_ready, 1);
        a_in_tt = f;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        a_in_tt = 16'($urandom);
        check("a_busy", a_in_ready, 0);
        cyc = 0;
        while (!a_out_valid && cyc < LAT4 + 8) begin
            step();
            cyc++;
        end
        check("a_latency", cyc, LAT4);
        got.tt = a_out_tt; got.perm = int'(a_out_perm);
        got.neg = int'(a_out_neg); got.oneg = int'(a_out_oneg);
        if (hold > 0) begin
            a_in_valid = 1'b1;
            a_in_tt = ~f;
            for (int h = 0; h < hold; h++) begin
                step();
                check("a_hold",
                      {a_out_valid, a_in_ready, a_out_tt, a_out_perm, a_out_neg, a_out_oneg},
                      {1'b1, 1'b0, got.tt, 5'(got.perm), 4'(got.neg), 1'(got.oneg)});
            end
            a_in_valid = 1'b0;
        end
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        check("a_release", {a_out_valid, a_in_ready}, 2'b01);
    endtask

    task automatic run_b(input logic [3:0] f, output res_t got);
        int cyc;
        check("b_ready_before", b_in_ready, 1);
        b_in_tt = f;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        b_in_tt = 4'($urandom);
        cyc = 0;
        while (!b_out_valid && cyc < LAT2 + 8) begin
            step();
            cyc++;
        end
        check("b_latency", cyc, LAT2);
        got.tt = {12'h0, b_out_tt}; got.perm = int'(b_out_perm);
        got.neg = int'(b_out_neg); got.oneg = int'(b_out_oneg);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        check("b_release", {b_out_valid, b_in_ready}, 2'b01);
    endtask

    task automatic cmp_model(input string tag, input res_t got, input res_t want);
        check({tag, "_tt"},   got.tt,   want.tt);
        check({tag, "_perm"}, got.perm, want.perm);
        check({tag, "_neg"},  got.neg,  want.neg);
        check({tag, "_oneg"}, got.oneg, want.oneg);
    endtask

    initial begin
        res_t        got, want, prev;
        logic [15:0] f;
        int          seen_valid;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", {a_in_ready, a_out_valid, a_out_tt, a_out_perm, a_out_neg, a_out_oneg},
              {1'b1, 27'd0});
        check("rst_b", {b_in_ready, b_out_valid, b_out_tt, b_out_perm, b_out_neg, b_out_oneg},
              {1'b1, 13'd0});
        rst = 1'b0;
        step();

        // constant one
        run_a(16'hFFFF, 0, got);
        check("ffff_tt",   got.tt,   (K == 2) ? 16'h0000 : 16'hFFFF);
        check("ffff_perm", got.perm, 0);
        check("ffff_neg",  got.neg,  0);
        check("ffff_oneg", got.oneg, (K == 2) ? 1 : 0);

        // single literal, with a long stall in DONE
        run_a(16'hAAAA, 50, got);
        check("aaaa_tt",   got.tt,   16'h00FF);
        check("aaaa_perm", got.perm, 9);
        check("aaaa_neg",  got.neg,  (K == 2) ? 0 : 8);
        check("aaaa_oneg", got.oneg, (K == 2) ? 1 : 0);
        cmp_model("aaaa_m", got, model(4, 16'hAAAA, K));

        // two-input AND; reported transform must reproduce the result
        run_a(16'h8888, 0, got);
        check("and_tt", got.tt, 16'h000F);
        x_tt = 16'h8888;
        x_perm = 5'(got.perm);
        x_neg = 4'(got.neg);
        x_oneg = 1'(got.oneg);
        #1;
        check("and_reapply", x_out, 16'h000F);
        cmp_model("and_m", got, model(4, 16'h8888, K));

        // parity is its own representative
        run_a(16'h6996, 0, got);
        check("par_tt", got.tt, 16'h6996);
        cmp_model("par_m", got, model(4, 16'h6996, K));
        prev = got;

        // reset in the middle of a scan
        a_in_tt = 16'h1234;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        repeat (200) step();
        check("scan_frozen", {a_out_valid, a_in_ready, a_out_tt, a_out_perm, a_out_neg, a_out_oneg},
              {1'b0, 1'b0, prev.tt, 5'(prev.perm), 4'(prev.neg), 1'(prev.oneg)});
        rst = 1'b1;
        #1;
        check("abort_outs", {a_out_valid, a_out_tt, a_out_perm, a_out_neg, a_out_oneg}, 27'd0);
        step();
        rst = 1'b0;
        check("abort_ready", {a_in_ready, a_out_valid}, 2'b10);
        seen_valid = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (a_out_valid) seen_valid++;
        end
        check("abort_no_valid", seen_valid, 0);

        run_a(16'hFFFF, 0, got);
        cmp_model("ffff2_m", got, model(4, 16'hFFFF, K));

        // randomized functions, dense and sparse
        for (int r = 0; r < 8; r++) begin
            f = 16'($urandom);
            if (r % 2 == 1) f = f & 16'($urandom);
            run_a(f, 0, got);
            cmp_model($sformatf("rnd%0d_%04h", r, f), got, model(4, f, K));
        end

        // two-input instance
        run_b(4'h8, got);
        check("b_and_tt", got.tt, 16'h0001);
        cmp_model("b_and_m", got, model(2, 16'h0008, K));
        for (int r = 0; r < 4; r++) begin
            f = 16'($urandom_range(0, 15));
            run_b(4'(f), got);
            cmp_model($sformatf("b_rnd%0d_%0h", r, f), got, model(2, f, K));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
